// File: rtl/sni_bridge.sv
// sni_bridge: host command engine between the UART byte link and the SDRAM
// arbiter. Host bytes land in a circular RX buffer and are parsed into
// PING / READ / WRITE / WAITNMI / FILL commands, which execute one SDRAM
// access at a time.
// Optional build macro: SNI_CHECKSUM_EN appends an XOR checksum byte to READ
// and WRITE responses (WRITE then reports header value 1).
module sni_bridge #(
    parameter int RXBUF_AW  = 9,
    parameter int LEN_BYTES = 2,
    parameter int LEN_W     = 8 * LEN_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        rbf,
    output logic        rx_ovf,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_data,
    input  logic [7:0]  sdram_q,
    output logic        sdram_rd_req,
    output logic        sdram_wr_req,
    input  logic        sdram_ready
);

    localparam int DEPTH = 1 << RXBUF_AW;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PING     = 4'd1;
    localparam logic [3:0] ST_ADDR     = 4'd2;
    localparam logic [3:0] ST_LEN      = 4'd3;
    localparam logic [3:0] ST_VAL      = 4'd4;
    localparam logic [3:0] ST_WAIT_NMI = 4'd5;
    localparam logic [3:0] ST_HDR      = 4'd6;
    localparam logic [3:0] ST_XREQ     = 4'd7;
    localparam logic [3:0] ST_XWAIT    = 4'd8;
    localparam logic [3:0] ST_PONG     = 4'd9;
`ifdef SNI_CHECKSUM_EN
    localparam logic [3:0] ST_CSUM     = 4'd10;
`endif

    localparam logic [2:0] CMD_PING  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_WAIT  = 3'd3;
    localparam logic [2:0] CMD_FILL  = 3'd4;

    logic [7:0]          rx_mem [DEPTH];
    logic [RXBUF_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rx_count;
    logic                rx_full, rx_empty, rx_wr, pop;
    logic [7:0]          rx_byte;
    logic                rx_ovf_q, rx_ovf_d;

    logic [3:0]          state_q, state_d, end_state;
    logic [2:0]          cmd_q, cmd_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d, hdr_val;
    logic [7:0]          val_q, val_d, wdata_q, wdata_d;
    logic                tx_start_q, tx_start_d, tx_busy_q, tx_busy_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic                vblank_q, vblank_d;
    logic                map_rom, map_wram, mapped, step;
`ifdef SNI_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // RX buffer status and address decode of the current transfer address
    always_comb begin
        rx_count   = wptr_q - rptr_q;
        rx_full    = (rx_count == {RXBUF_AW{1'b1}});
        rx_empty   = (wptr_q == rptr_q);
        rx_wr      = rx_strobe && !rx_full;
        rx_byte    = rx_mem[rptr_q];
        map_rom    = (addr_q[23:20] != 4'hF);
        map_wram   = (addr_q[23:16] == 8'hF5) || (addr_q[23:16] == 8'hF6);
        mapped     = map_rom || map_wram;
        sdram_addr = map_rom ? {1'b0, addr_q}
                             : {1'b1, 7'h00, ~addr_q[16], addr_q[15:0]};
    end

    // Response header value and post-transfer state for the active command
    always_comb begin
        hdr_val   = '0;
        end_state = ST_IDLE;
        case (cmd_q)
            CMD_PING:  hdr_val = LEN_W'(1);
            CMD_READ:  hdr_val = len_q;
`ifdef SNI_CHECKSUM_EN
            CMD_WRITE: hdr_val = LEN_W'(1);
`endif
            default:   hdr_val = '0;
        endcase
`ifdef SNI_CHECKSUM_EN
        if (cmd_q == CMD_READ || cmd_q == CMD_WRITE)
            end_state = ST_CSUM;
`endif
    end

    // Command parser / executor; frozen entirely while a TX byte is in flight
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        val_d      = val_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        pop        = 1'b0;
        step       = 1'b0;
        vblank_d   = vblank;
`ifdef SNI_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        if (!tx_busy_q) begin
            case (state_q)
                ST_IDLE: if (!rx_empty) begin
                    pop    = 1'b1;
                    idx_d  = '0;
                    addr_d = '0;
                    len_d  = '0;
`ifdef SNI_CHECKSUM_EN
                    csum_d = '0;
`endif
                    case (rx_byte)
                        8'h00: begin cmd_d = CMD_PING; state_d = ST_PING; end
                        8'h01, 8'h02, 8'h04: begin
                            cmd_d   = rx_byte[2:0];
                            state_d = ST_ADDR;
                        end
                        8'h03: begin cmd_d = CMD_WAIT; state_d = ST_WAIT_NMI; end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_PING: if (!rx_empty) begin
                    pop     = 1'b1;
                    val_d   = rx_byte;
                    state_d = ST_HDR;
                end
                ST_ADDR: if (!rx_empty) begin
                    pop    = 1'b1;
                    addr_d = addr_q | (24'(rx_byte) << {idx_q, 3'b000});
                    if (idx_q == 2'd2) begin
                        idx_d   = '0;
                        state_d = ST_LEN;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_LEN: if (!rx_empty) begin
                    pop   = 1'b1;
                    len_d = len_q | (LEN_W'(rx_byte) << {idx_q, 3'b000});
                    if (idx_q == 2'(LEN_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = (cmd_q == CMD_FILL) ? ST_VAL : ST_HDR;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_VAL: if (!rx_empty) begin
                    pop     = 1'b1;
                    val_d   = rx_byte;
                    state_d = ST_HDR;
                end
                ST_WAIT_NMI: if (vblank && !vblank_q) begin
                    idx_d   = '0;
                    state_d = ST_HDR;
                end
                ST_HDR: begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'(hdr_val >> {idx_q, 3'b000});
                    if (idx_q == 2'(LEN_BYTES - 1)) begin
                        idx_d = '0;
                        if (cmd_q == CMD_PING)
                            state_d = ST_PONG;
                        else if (cmd_q == CMD_WAIT)
                            state_d = ST_IDLE;
                        else if (len_q == '0)
                            state_d = end_state;
                        else
                            state_d = ST_XREQ;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_PONG: begin
                    tx_start_d = 1'b1;
                    tx_data_d  = val_q;
                    state_d    = ST_IDLE;
                end
                ST_XREQ: begin
                    case (cmd_q)
                        CMD_READ: begin
                            if (mapped) begin
                                rd_req_d = 1'b1;
                                state_d  = ST_XWAIT;
                            end else begin
                                tx_start_d = 1'b1;
                                tx_data_d  = 8'h00;
                                step       = 1'b1;
                            end
                        end
                        CMD_WRITE: if (!rx_empty) begin
                            pop = 1'b1;
`ifdef SNI_CHECKSUM_EN
                            csum_d = csum_q ^ rx_byte;
`endif
                            if (mapped) begin
                                wr_req_d = 1'b1;
                                wdata_d  = rx_byte;
                                state_d  = ST_XWAIT;
                            end else begin
                                step = 1'b1;
                            end
                        end
                        default: begin
                            if (mapped) begin
                                wr_req_d = 1'b1;
                                wdata_d  = val_q;
                                state_d  = ST_XWAIT;
                            end else begin
                                step = 1'b1;
                            end
                        end
                    endcase
                end
                ST_XWAIT: if (sdram_ready && !rd_req_q && !wr_req_q) begin
                    if (cmd_q == CMD_READ) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = sdram_q;
`ifdef SNI_CHECKSUM_EN
                        csum_d = csum_q ^ sdram_q;
`endif
                    end
                    step = 1'b1;
                end
`ifdef SNI_CHECKSUM_EN
                ST_CSUM: begin
                    tx_start_d = 1'b1;
                    tx_data_d  = csum_q;
                    state_d    = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        if (step) begin
            addr_d  = addr_q + 24'd1;
            len_d   = len_q - LEN_W'(1);
            state_d = (len_q == LEN_W'(1)) ? end_state : ST_XREQ;
        end

        wptr_d   = wptr_q + (rx_wr ? RXBUF_AW'(1) : '0);
        rptr_d   = rptr_q + (pop ? RXBUF_AW'(1) : '0);
        rx_ovf_d = rx_ovf_q || (rx_strobe && rx_full);

        // busy must rise together with the start pulse so no second start slips out
        if (tx_start_d)
            tx_busy_d = 1'b1;
        else if (tx_done)
            tx_busy_d = 1'b0;
        else
            tx_busy_d = tx_busy_q;
    end

    // RX buffer storage; stale contents are harmless once pointers reset
    always_ff @(posedge clk) begin
        if (rx_wr)
            rx_mem[wptr_q] <= rx_data;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_PING;
            idx_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            val_q      <= '0;
            wdata_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_busy_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rx_ovf_q   <= 1'b0;
            vblank_q   <= 1'b0;
`ifdef SNI_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            val_q      <= val_d;
            wdata_q    <= wdata_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rx_ovf_q   <= rx_ovf_d;
            vblank_q   <= vblank_d;
`ifdef SNI_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign rbf          = rx_full;
    assign rx_ovf       = rx_ovf_q;
    assign sdram_data   = wdata_q;
    assign sdram_rd_req = rd_req_q;
    assign sdram_wr_req = wr_req_q;

endmodule
